// File: rtl/packetizer_2_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : packetizer_2_sub
// Brief    : Packs data words into two-flit NoC packets behind a 2-entry
//            elastic buffer with registered outputs and a sent-packet counter.
// Revision : 1.0 - initial release
// ============================================================================
module packetizer_2_sub #(
   parameter int WIDTH_PKT        = 36,
   parameter int WIDTH_DATA       = 12,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int ADDRESS_WIDTH    = 4,
   parameter int CNT_WIDTH        = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WIDTH_DATA-1:0]       data_in,
   input  logic [ADDRESS_WIDTH-1:0]    dest_in,
   input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
   input  logic                        valid_in,
   output logic                        ready_out,
   output logic [WIDTH_PKT-1:0]        data_out,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic [CNT_WIDTH-1:0]        pkt_count
);

   localparam int c_WIDTH_FLIT     = WIDTH_PKT / 2;
   localparam int c_WIDTH_DATA_IDL = WIDTH_PKT - 6 - 2*VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
   localparam int c_HEAD_DATA_W    = c_WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
   localparam int c_TAIL_DATA_W    = c_WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
   localparam int c_DATA_SHIFT     = c_WIDTH_DATA_IDL - WIDTH_DATA;
   localparam logic [1:0] c_CNT_EMPTY = 2'd0;
   localparam logic [1:0] c_CNT_FULL  = 2'd2;

   logic [c_WIDTH_DATA_IDL-1:0] w_full_data;
   logic [WIDTH_PKT-1:0]        w_packet;
   logic                        w_accept;
   logic                        w_xfer;

   logic [WIDTH_PKT-1:0]        r_mem [2];
   logic                        r_wr_ptr;
   logic                        r_rd_ptr;
   logic [1:0]                  r_count;
   logic [CNT_WIDTH-1:0]        r_pkt_count;

   // Payload sits MSB-aligned in the idle field, low unused bits zero.
   assign w_full_data = c_WIDTH_DATA_IDL'(data_in) << c_DATA_SHIFT;

   assign w_packet = {3'b110, vc_in, dest_in,
                      w_full_data[c_WIDTH_DATA_IDL-1 -: c_HEAD_DATA_W],
                      3'b101, vc_in,
                      w_full_data[c_TAIL_DATA_W-1:0]};

   // Handshake flags come only from registered occupancy.
   assign ready_out = (r_count != c_CNT_FULL);
   assign valid_out = (r_count != c_CNT_EMPTY);
   assign data_out  = r_mem[r_rd_ptr];
   assign pkt_count = r_pkt_count;

   assign w_accept = valid_in  & ready_out;
   assign w_xfer   = valid_out & ready_in;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
      end else if (w_accept) begin
         r_mem[r_wr_ptr] <= w_packet;
         r_wr_ptr        <= ~r_wr_ptr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ptr    <= 1'b0;
         r_pkt_count <= '0;
      end else if (w_xfer) begin
         r_rd_ptr    <= ~r_rd_ptr;
         r_pkt_count <= r_pkt_count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= c_CNT_EMPTY;
      end else begin
         case ({w_accept, w_xfer})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_packetizer_2_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_packetizer_2_sub
// Brief    : Directed and scoreboarded bench for packetizer_2_sub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packetizer_2_sub;

   logic        clk;
   logic        rst;
   logic [11:0] data_in;
   logic [3:0]  dest_in;
   logic [0:0]  vc_in;
   logic        valid_in;
   logic        ready_in;
   logic        ready_out,  ready_out4;
   logic        valid_out,  valid_out4;
   logic [35:0] data_out,   data_out4;
   logic [15:0] pkt_count;
   logic [3:0]  pkt_count4;

   int          n_total = 0;
   int          n_bad   = 0;
   int          n_xfer  = 0;
   logic [35:0] sb_q [$];

   packetizer_2_sub u_dut (
      .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in),
      .vc_in(vc_in), .valid_in(valid_in), .ready_out(ready_out),
      .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
      .pkt_count(pkt_count)
   );

   packetizer_2_sub #(.CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in),
      .vc_in(vc_in), .valid_in(valid_in), .ready_out(ready_out4),
      .data_out(data_out4), .valid_out(valid_out4), .ready_in(ready_in),
      .pkt_count(pkt_count4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] mk_pkt(input logic [11:0] d, input logic [3:0] de,
                                          input logic c);
      mk_pkt = {3'b110, c, de, d[11:2], 3'b101, c, d[1:0], 12'h000};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [11:0] d, input logic [3:0] de,
                        input logic c, input logic r);
      valid_in = v;
      data_in  = d;
      dest_in  = de;
      vc_in    = c;
      ready_in = r;
   endtask

   // Inputs change just after posedge, so negedge sees what the next edge will use.
   always @(negedge clk) begin
      if (!rst) begin
         sb_q.delete();
         n_xfer = 0;
      end else begin
         if (valid_out && ready_in) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 64'd1, 64'd0);
            end else begin
               check("sb_data", {28'd0, data_out}, {28'd0, sb_q.pop_front()});
            end
            n_xfer++;
         end
         if (valid_in && ready_out)
            sb_q.push_back(mk_pkt(data_in, dest_in, vc_in[0]));
      end
   end

   logic [35:0] held;
   logic        r_rand_v;

   initial begin
      rst = 1'b1;
      drive(1'b0, 12'h000, 4'h0, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      check("rst_valid_out", {63'd0, valid_out}, 64'd0);
      check("rst_ready_out", {63'd0, ready_out}, 64'd1);
      check("rst_data_out",  {28'd0, data_out},  64'd0);
      check("rst_pkt_count", {48'd0, pkt_count}, 64'd0);
      step();
      step();
      rst = 1'b1;
      check("post_rst_ready", {63'd0, ready_out}, 64'd1);

      // Format check
      drive(1'b1, 12'hABC, 4'h5, 1'b1, 1'b1);
      step();
      drive(1'b0, 12'h000, 4'h0, 1'b0, 1'b1);
      check("fmt_head",  {46'd0, data_out[35:18]}, 64'h356AF);
      check("fmt_tail",  {46'd0, data_out[17:0]},  64'h2C000);
      check("fmt_valid", {63'd0, valid_out}, 64'd1);
      step();
      check("fmt_cnt",   {48'd0, pkt_count}, 64'd1);
      check("fmt_empty", {63'd0, valid_out}, 64'd0);

      // Streaming 100 words
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 12'(i * 37 + 5), 4'(i), 1'(i), 1'b1);
         check("stream_ready", {63'd0, ready_out}, 64'd1);
         step();
         check("stream_valid", {63'd0, valid_out}, 64'd1);
      end
      drive(1'b0, 12'h000, 4'h0, 1'b0, 1'b1);
      step();
      step();
      check("stream_cnt", {48'd0, pkt_count}, 64'd101);

      // Backpressure: three words offered while stalled
      drive(1'b1, 12'h111, 4'h1, 1'b0, 1'b0);
      step();
      drive(1'b1, 12'h222, 4'h2, 1'b1, 1'b0);
      step();
      check("bp_full", {63'd0, ready_out}, 64'd0);
      drive(1'b1, 12'h333, 4'h3, 1'b0, 1'b0);
      held = data_out;
      check("bp_head", {28'd0, data_out}, {28'd0, mk_pkt(12'h111, 4'h1, 1'b0)});
      step();
      check("bp_still_full", {63'd0, ready_out}, 64'd0);
      check("bp_stable", {28'd0, data_out}, {28'd0, held});
      step();
      check("bp_stable2", {28'd0, data_out}, {28'd0, held});
      check("bp_valid", {63'd0, valid_out}, 64'd1);
      ready_in = 1'b1;
      step();
      check("bp_second", {28'd0, data_out}, {28'd0, mk_pkt(12'h222, 4'h2, 1'b1)});
      check("bp_slot", {63'd0, ready_out}, 64'd1);
      step();
      drive(1'b0, 12'h000, 4'h0, 1'b0, 1'b1);
      check("bp_third", {28'd0, data_out}, {28'd0, mk_pkt(12'h333, 4'h3, 1'b0)});
      step();
      check("bp_drained", {63'd0, valid_out}, 64'd0);
      check("bp_cnt", {48'd0, pkt_count}, 64'd104);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r_rand_v = 1'($urandom_range(0, 1));
         drive(r_rand_v, 12'($urandom), 4'($urandom), 1'($urandom),
               1'($urandom_range(0, 3) != 0));
         step();
      end
      drive(1'b0, 12'h000, 4'h0, 1'b0, 1'b1);
      step();
      step();
      step();
      check("rnd_drained", {63'd0, valid_out}, 64'd0);
      check("rnd_sb_empty", 64'(sb_q.size()), 64'd0);
      check("rnd_cnt",  {48'd0, pkt_count},  64'(n_xfer[15:0]));
      check("rnd_cnt4", {60'd0, pkt_count4}, 64'(n_xfer[3:0]));

      // Reset with two packets buffered
      drive(1'b1, 12'h5A5, 4'h9, 1'b1, 1'b0);
      step();
      drive(1'b1, 12'hA5A, 4'h6, 1'b0, 1'b0);
      step();
      drive(1'b0, 12'h000, 4'h0, 1'b0, 1'b0);
      check("mid_full", {63'd0, ready_out}, 64'd0);
      #2 rst = 1'b0;
      #1;
      check("mid_valid", {63'd0, valid_out}, 64'd0);
      check("mid_cnt",   {48'd0, pkt_count}, 64'd0);
      check("mid_data",  {28'd0, data_out},  64'd0);
      step();
      rst = 1'b1;
      ready_in = 1'b1;
      check("mid_ready", {63'd0, ready_out}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid_no_emit", {63'd0, valid_out}, 64'd0);
      end

      // Counter wrap at 4 bits
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 12'(i + 100), 4'(i), 1'b0, 1'b1);
         step();
      end
      drive(1'b0, 12'h000, 4'h0, 1'b0, 1'b1);
      step();
      step();
      check("wrap_cnt4", {60'd0, pkt_count4}, 64'd1);
      check("wrap_cnt",  {48'd0, pkt_count},  64'd17);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
